// File: rtl/serial_tx_16bit_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_16bit_if
// Description : Handshake, control and serial-output bundle for the 16-bit
//               parallel-in / serial-out transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_tx_16bit_if;
  // Upstream word offer
  logic [15:0] i_data;
  logic [3:0]  i_len;
  logic        i_msb_first;
  logic        i_valid;
  logic        o_ready;
  // Frame control
  logic        i_stall;
  logic        i_abort;
  // Serial output side
  logic [3:0]  o_sel;
  logic        o_bit;
  logic        o_bit_valid;
  logic        o_last;
  logic        o_busy;

  // Transmitter side
  modport slave (
    input  i_data, i_len, i_msb_first, i_valid, i_stall, i_abort,
    output o_ready, o_sel, o_bit, o_bit_valid, o_last, o_busy
  );

  // Upstream / controller side
  modport master (
    output i_data, i_len, i_msb_first, i_valid, i_stall, i_abort,
    input  o_ready, o_sel, o_bit, o_bit_valid, o_last, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_tx_16bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_16bit
// Description : Captures a 16-bit word and presents it one bit per cycle,
//               LSB- or MSB-first, with a programmable frame length of 1..16
//               bits, downstream stall, frame abort and zero-bubble
//               back-to-back frames. The bit index is exported on o_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_16bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  serial_tx_16bit_if.slave   bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_data;
  logic [3:0]  r_len;
  logic        r_msb_first;
  logic [3:0]  r_sel;

  logic        w_shift;
  logic        w_last;
  logic        w_ready;
  logic        w_accept;
  logic        w_abort;

  assign w_shift = (r_state == S_SHIFT);

  // End index depends on the captured order: 0 when counting down, the
  // captured length when counting up.
  assign w_last  = w_shift && (r_msb_first ? (r_sel == 4'd0) : (r_sel == r_len));

  // Abort only has meaning while a frame is in flight.
  assign w_abort = w_shift && bus.i_abort;

  // Idle always accepts; in SHIFT a new word may only be taken on an
  // unstalled, non-aborted final bit so consecutive frames abut.
  assign w_ready  = w_shift ? (w_last && !bus.i_stall && !w_abort) : 1'b1;
  assign w_accept = bus.i_valid && w_ready;

  // Frame sequencing: abort beats accept, accept beats advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= 16'd0;
      r_len       <= 4'd0;
      r_msb_first <= 1'b0;
      r_sel       <= 4'd0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_state     <= S_SHIFT;
      r_data      <= bus.i_data;
      r_len       <= bus.i_len;
      r_msb_first <= bus.i_msb_first;
      r_sel       <= bus.i_msb_first ? bus.i_len : 4'd0;
    end else if (w_shift && !bus.i_stall) begin
      if (w_last) begin
        r_state <= S_IDLE;
      end else if (r_msb_first) begin
        r_sel <= r_sel - 4'd1;
      end else begin
        r_sel <= r_sel + 4'd1;
      end
    end
  end

  // Outputs are pure functions of registered state apart from o_ready.
  assign bus.o_ready     = w_ready;
  assign bus.o_sel       = r_sel;
  assign bus.o_bit       = w_shift ? r_data[r_sel] : RESET_BIT;
  assign bus.o_bit_valid = w_shift;
  assign bus.o_last      = w_last;
  assign bus.o_busy      = w_shift;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_16bit
// Description : Self-checking bench for serial_tx_16bit: table-driven frames
//               plus hand sequences for stall, back-to-back, abort and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_16bit;

  localparam logic RST_BIT = 1'b1;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  len;
    logic        msb;
    logic [15:0] stream;  // expected bits in transmit order, bit k = k-th bit
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic       b;
    logic       last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  serial_tx_16bit_if bus_if ();

  serial_tx_16bit #(.RESET_BIT(RST_BIT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the expected per-bit records of one frame.
  task automatic push_frame(input logic [3:0] len, input logic msb, input logic [15:0] stream);
    exp_t e;
    for (int k = 0; k <= int'(len); k++) begin
      e.sel  = msb ? 4'(int'(len) - k) : 4'(k);
      e.b    = stream[k];
      e.last = (k == int'(len));
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: compares every presented bit, pops on advance.
  always @(negedge clk) begin
    if (rst_n && bus_if.o_bit_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: unexpected bit sel=%0d at t=%0t", bus_if.o_sel, $time);
      end else begin
        exp_t e;
        e = sb[0];
        check("mon_sel",  int'(bus_if.o_sel),  int'(e.sel));
        check("mon_bit",  int'(bus_if.o_bit),  int'(e.b));
        check("mon_last", int'(bus_if.o_last), int'(e.last));
        check("mon_ready", int'(bus_if.o_ready),
              int'(e.last && !bus_if.i_stall && !bus_if.i_abort));
        if (bus_if.i_abort) sb.delete();
        else if (!bus_if.i_stall) void'(sb.pop_front());
      end
    end
  end

  task automatic send_frame(input vec_t v);
    int cnt;
    check("ready_idle", int'(bus_if.o_ready), 1);
    push_frame(v.len, v.msb, v.stream);
    bus_if.i_data      = v.data;
    bus_if.i_len       = v.len;
    bus_if.i_msb_first = v.msb;
    bus_if.i_valid     = 1'b1;
    @(posedge clk); #1;
    bus_if.i_valid     = 1'b0;
    bus_if.i_data      = 16'($urandom);
    bus_if.i_len       = 4'($urandom);
    bus_if.i_msb_first = 1'($urandom);
    cnt = 0;
    while (bus_if.o_busy && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("frame_cycles", cnt, int'(v.len) + 1);
    check("ready_after", int'(bus_if.o_ready), 1);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"},  int'(bus_if.o_busy), 0);
    check({name, "_valid"}, int'(bus_if.o_bit_valid), 0);
    check({name, "_bit"},   int'(bus_if.o_bit), int'(RST_BIT));
    check({name, "_last"},  int'(bus_if.o_last), 0);
    check({name, "_ready"}, int'(bus_if.o_ready), 1);
  endtask

  vec_t vecs [8];

  initial begin
    int cnt;
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{16'hA5C3, 4'd15, 1'b0, 16'hA5C3};
    vecs[1] = '{16'h000B, 4'd3,  1'b1, 16'h000D};
    vecs[2] = '{16'hFFFF, 4'd7,  1'b0, 16'h00FF};
    vecs[3] = '{16'h8000, 4'd15, 1'b1, 16'h0001};
    vecs[4] = '{16'h1234, 4'd0,  1'b0, 16'h0000};
    vecs[5] = '{16'h0001, 4'd0,  1'b1, 16'h0001};
    vecs[6] = '{16'hC000, 4'd15, 1'b1, 16'h0003};
    vecs[7] = '{16'h00F0, 4'd7,  1'b1, 16'h000F};

    rst_n              = 1'b0;
    bus_if.i_data      = 16'd0;
    bus_if.i_len       = 4'd0;
    bus_if.i_msb_first = 1'b0;
    bus_if.i_valid     = 1'b0;
    bus_if.i_stall     = 1'b0;
    bus_if.i_abort     = 1'b0;
    #3;
    check_idle("reset");
    check("reset_sel", int'(bus_if.o_sel), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("post_reset");

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i]);
      check_idle("after_frame");
    end

    // Stall: LSB-first 0x0005, 3 bits, stall 3 cycles while sel=1
    push_frame(4'd2, 1'b0, 16'h0005);
    bus_if.i_data = 16'h0005; bus_if.i_len = 4'd2; bus_if.i_msb_first = 1'b0;
    bus_if.i_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.i_valid = 1'b0;
    cnt = 1;
    @(posedge clk); #1;
    cnt++;
    check("stall_sel_start", int'(bus_if.o_sel), 1);
    bus_if.i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      cnt++;
      check("stall_sel_hold", int'(bus_if.o_sel), 1);
      check("stall_bit_hold", int'(bus_if.o_bit), 0);
    end
    bus_if.i_stall = 1'b0;
    while (bus_if.o_busy && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("stall_frame_cycles", cnt - 1, 6);
    check("stall_sb_drained", sb.size(), 0);

    // Back-to-back single-bit frames, i_valid held high
    push_frame(4'd0, 1'b0, 16'h0001);
    bus_if.i_data = 16'h0001; bus_if.i_len = 4'd0; bus_if.i_msb_first = 1'b0;
    bus_if.i_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_valid1", int'(bus_if.o_bit_valid), 1);
    check("b2b_ready1", int'(bus_if.o_ready), 1);
    push_frame(4'd0, 1'b0, 16'h0000);
    bus_if.i_data = 16'h0000;
    @(posedge clk); #1;
    bus_if.i_valid = 1'b0;
    check("b2b_valid2", int'(bus_if.o_bit_valid), 1);
    check("b2b_bit2", int'(bus_if.o_bit), 0);
    @(posedge clk); #1;
    check_idle("b2b_end");
    check("b2b_sb_drained", sb.size(), 0);

    // Abort at sel=5 of a 16-bit LSB-first frame, with a word offered
    push_frame(4'd15, 1'b0, 16'h3C5A);
    bus_if.i_data = 16'h3C5A; bus_if.i_len = 4'd15; bus_if.i_msb_first = 1'b0;
    bus_if.i_valid = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_sel", int'(bus_if.o_sel), 5);
    bus_if.i_abort = 1'b1;
    check("abort_ready", int'(bus_if.o_ready), 0);
    @(posedge clk); #1;
    bus_if.i_abort = 1'b0;
    bus_if.i_valid = 1'b0;
    check_idle("abort_next");
    check("abort_sb_flushed", sb.size(), 0);

    // Abort in IDLE does not block an accept
    push_frame(4'd0, 1'b1, 16'h0001);
    bus_if.i_data = 16'h0001; bus_if.i_len = 4'd0; bus_if.i_msb_first = 1'b1;
    bus_if.i_valid = 1'b1;
    bus_if.i_abort = 1'b1;
    @(posedge clk); #1;
    bus_if.i_valid = 1'b0;
    bus_if.i_abort = 1'b0;
    check("idle_abort_busy", int'(bus_if.o_busy), 1);
    @(posedge clk); #1;
    check_idle("idle_abort_end");

    // Asynchronous reset mid-frame
    push_frame(4'd15, 1'b1, 16'hFFFF);
    bus_if.i_data = 16'hFFFF; bus_if.i_len = 4'd15; bus_if.i_msb_first = 1'b1;
    bus_if.i_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_busy", int'(bus_if.o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    check("async_reset_sel", int'(bus_if.o_sel), 0);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_no_resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_tx_16bit.md
Name: serial_tx_16bit

Overview:
- Parallel-in, serial-out transmitter that issues one bit per cycle from a captured 16-bit word.
- A 4-bit bit-index counter selects the transmitted bit; the same index is exported on o_sel so a downstream 16-to-1 select stage or a bench can be driven from it.
- Frame length (1 to 16 bits), bit order, stall and abort are supported.
- Sits in the common datapath library as the sequencing stage feeding single-bit select logic (serial debug/trace output, bit-serial peripherals).

Parameters:
- RESET_BIT, 1'b0, value driven on o_bit while idle and after reset.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_data  input  16  word to transmit, sampled on accept
- i_len  input  4  frame length minus one (0 means 1 bit, 15 means 16 bits), sampled on accept
- i_msb_first  input  1  1 means send from index i_len down to 0; 0 means send from 0 up to i_len; sampled on accept
- i_valid  input  1  upstream offers a word
- o_ready  output  1  block can accept a word this cycle
- i_stall  input  1  downstream hold; freezes the current bit
- i_abort  input  1  drop the current frame
- o_sel  output  4  current bit index
- o_bit  output  1  current serial bit, equal to the captured word at index o_sel
- o_bit_valid  output  1  o_bit is a valid frame bit
- o_last  output  1  current bit is the final bit of the frame
- o_busy  output  1  frame in progress

Behaviour:
- Reset values (asynchronous on i_rst_n=0):
  - State = IDLE.
  - Data register = 0, length register = 0, order register = 0, o_sel = 0.
  - o_bit = RESET_BIT, o_bit_valid = 0, o_last = 0, o_busy = 0, o_ready = 1.
- Reset mid-frame: the frame is discarded; nothing resumes after release.
- States:
  - IDLE: o_ready=1, o_bit_valid=0, o_busy=0, o_bit=RESET_BIT.
  - SHIFT: o_busy=1, o_bit_valid=1.
- Accept occurs on i_valid & o_ready at the rising edge.
  - Captures i_data, i_len, i_msb_first.
  - Loads o_sel with i_len if i_msb_first=1, else with 0.
  - Next state = SHIFT.
  - Latency: the first bit is valid on the cycle after accept.
- o_bit and o_last are combinational from registered state only; there is no input-to-output combinational path.
- o_last is high in SHIFT when o_sel equals the end index: 0 if MSB-first, the length register if LSB-first.
- SHIFT advance rules:
  - i_stall=1: hold o_sel and state; the bit stays presented.
  - i_stall=0 and not o_last: o_sel increments (LSB-first) or decrements (MSB-first). The counter never wraps within a frame.
  - i_stall=0 and o_last: the frame ends.
- o_ready in SHIFT = o_last & ~i_stall. This gives zero-bubble back-to-back frames.
  - If a new word is accepted on the last-bit cycle, the next cycle is SHIFT with the new word.
  - Otherwise the next state is IDLE.
- i_abort:
  - In SHIFT, abort takes priority over stall and advance. Next state = IDLE, o_ready is forced 0 that cycle, and no accept occurs.
  - In IDLE, abort is ignored; accept is unaffected.
- 1-bit frame (i_len=0): o_last is high on the first SHIFT cycle; the frame lasts exactly 1 cycle unless stalled.
- Changes to i_data, i_len or i_msb_first during SHIFT have no effect on the frame in progress.
- An unstalled frame of N bits occupies exactly N SHIFT cycles.

Test Plan:
- Basic LSB-first frame:
  - Stimulus: reset, then accept i_data=16'hA5C3, i_len=15, i_msb_first=0.
  - Response: 16 cycles of o_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - Response: o_sel runs 0..15, o_last only on o_sel=15, then IDLE with o_ready=1.
- MSB-first short frame:
  - Stimulus: i_data=16'h000B, i_len=3, i_msb_first=1.
  - Response: o_sel runs 3,2,1,0 with bits 1,0,1,1; o_last on o_sel=0; o_busy drops after 4 cycles.
- Stall:
  - Stimulus: LSB-first i_data=16'h0005, i_len=2; assert i_stall for 3 cycles while o_sel=1.
  - Response: o_sel=1 and o_bit=0 are held for 4 cycles total; the frame completes in 6 cycles with no bit lost or repeated after release.
- Back-to-back frames:
  - Stimulus: hold i_valid=1; first word 16'h0001 with i_len=0, second word 16'h0000 with i_len=0.
  - Response: o_ready=1 on the single SHIFT cycle, the second frame starts next cycle, and o_bit_valid stays high for 2 consecutive cycles with bits 1,0.
- Abort and async reset:
  - Abort stimulus: i_abort pulsed at o_sel=5 of a 16-bit frame.
  - Abort response: IDLE next cycle, o_bit_valid=0, o_ready=0 during the abort cycle.
  - Reset stimulus: i_rst_n dropped mid-frame (not clock-aligned).
  - Reset response: outputs go immediately to reset values and o_bit=RESET_BIT.
